inst_fetch: RTL

Instruction fetch unit: the reader side of the instruction memory `Ins_Mem`. It owns the program counter and drives `Ins_Mem.addrss`. It samples the combinational `Ins_Mem.data` into a small buffer and presents instructions to decode through a valid/ready handshake. It sits between `Ins_Mem` and the decode stage, and accepts branch/jump redirects from execute.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_buffer.sv | 67 ++++++
 rtl/inst_fetch.sv | 72 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the instruction path.
// Used by Ins_Mem, inst_fetch and decode.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int FETCH_DEPTH = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef logic [ADDR_W-1:0] inst_addr_t;
  typedef logic [DATA_W-1:0] inst_word_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_word_t data;
  } fetch_entry_t;

  function automatic inst_addr_t pc_next(input inst_addr_t pc);
    return pc + inst_addr_t'(1);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, data} pairs.
// Flush empties it in one cycle; async reset also clears entries.
module fetch_buffer #(
  parameter int EW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [EW-1:0] i_wdata,
  output logic [EW-1:0] o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_cnt;

  logic w_rd;
  logic w_wr;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_rdata = r_mem[r_rptr];

  // Push into a full buffer is only legal when the head leaves too.
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & ~i_flush & (~o_full | w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads Ins_Mem and buffers
// {pc, data} for decode; execute redirects flush the buffer.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int DEPTH = cpu_pkg::FETCH_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] imem_addrss,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int EW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0]       r_pc;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_full;
  logic                    w_empty;
  logic [EW-1:0]           w_rdata;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_unused;

  assign w_unused = &{1'b0, w_count};

  assign imem_addrss = r_pc;
  assign inst_valid  = ~w_empty;
  assign inst_pc     = w_rdata[EW-1:DATA_W];
  assign inst_data   = w_rdata[DATA_W-1:0];

  assign w_pop  = inst_valid & inst_ready;
  assign w_push = enable & ~redirect_valid & (~w_full | w_pop);

  // A refused push leaves the PC in place so the address is retried.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  fetch_buffer #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata ({r_pc, imem_data}),
    .o_rdata (w_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
